// File: rtl/ifetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package ifetch_pkg;

   localparam int unsigned IFETCH_ADDR_W   = 32;
   localparam int unsigned IFETCH_DATA_W   = 32;
   localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
   localparam int unsigned IFETCH_TIMEOUT  = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } ifetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface ifetch_if #(
   parameter int unsigned ADDR_W = ifetch_pkg::IFETCH_ADDR_W,
   parameter int unsigned DATA_W = ifetch_pkg::IFETCH_DATA_W
) ();

   logic              o_imem_req;
   logic [ADDR_W-1:0] o_imem_addr;
   logic              i_imem_ack;
   logic [DATA_W-1:0] i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_ack,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_ack,
      output i_imem_rdata
   );

endinterface

// File: rtl/ifetch_timeout_ctr.sv
// Wait-state counter for an outstanding fetch; flags expiry on the last allowed
// REQ cycle that still has no acknowledge.
module ifetch_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_ack,
   output logic o_expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count consecutive unacknowledged REQ cycles; any other cycle clears.
   always_comb begin
      cnt_d = {CW{1'b0}};
      if (i_run && !i_ack) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = {CW{1'b0}};
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = i_run && !i_ack && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC ownership, held memory request, instruction register.
// Optional wait-state timeout enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned       ADDR_W      = IFETCH_ADDR_W,
   parameter int unsigned       DATA_W      = IFETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = IFETCH_RESET_PC[ADDR_W-1:0],
   parameter int unsigned       TIMEOUT_CYC = IFETCH_TIMEOUT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_fetch_req,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_fetch_busy,
   output logic              o_instr_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pc_next,
   output logic              o_fetch_err,
   ifetch_if.master          imem
);

   ifetch_state_e     state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] opc_q, opc_d;
   logic              valid_q, valid_d;
   logic              squash_q, squash_d;
   logic              err_q, err_d;
   logic              timeout_s;

`ifdef IFETCH_TIMEOUT_EN
   ifetch_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_run     (state_q == ST_REQ),
      .i_ack     (imem.i_imem_ack),
      .o_expired (timeout_s)
   );
`else
   logic unused_cfg_s;
   assign unused_cfg_s = |TIMEOUT_CYC;
   assign timeout_s    = 1'b0;
`endif

   // Next-state and datapath decode; a redirect always wins the PC.
   always_comb begin
      state_d  = state_q;
      pc_d     = i_redirect ? i_redirect_pc : pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      squash_d = squash_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (i_fetch_req && !i_redirect) begin
               addr_d   = pc_q;
               squash_d = 1'b0;
               err_d    = 1'b0;
               state_d  = ST_REQ;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (imem.i_imem_ack) begin
               if (!squash_q && !i_redirect) begin
                  instr_d = imem.i_imem_rdata;
                  opc_d   = addr_q;
                  pc_d    = addr_q + ADDR_W'(1);
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (timeout_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               squash_d = squash_q | i_redirect;
               state_d  = ST_REQ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= {ADDR_W{1'b0}};
         instr_q  <= {DATA_W{1'b0}};
         opc_q    <= {ADDR_W{1'b0}};
         valid_q  <= 1'b0;
         squash_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         opc_q    <= opc_d;
         valid_q  <= valid_d;
         squash_q <= squash_d;
         err_q    <= err_d;
      end
   end

   // Request and busy decode straight from state so reset drops them at once.
   assign imem.o_imem_req  = (state_q == ST_REQ);
   assign imem.o_imem_addr = addr_q;
   assign o_fetch_busy     = (state_q != ST_IDLE);
   assign o_instr_valid    = valid_q;
   assign o_instr          = instr_q;
   assign o_pc             = opc_q;
   assign o_pc_next        = pc_q;
   assign o_fetch_err      = err_q;

endmodule
